// File: rtl/router_pkt_fifo.sv
// Packet FIFO for one router output channel: tags header bytes on write and
// counts the header's payload length on read to flag the final (parity) byte.
module router_pkt_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int LEN_MSB   = 7,
    parameter int LEN_LSB   = 2,
    parameter int AF_THRESH = 14
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     soft_reset,
    input  logic                     write_enb,
    input  logic                     read_enb,
    input  logic                     lfd_state,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_valid,
    output logic                     pkt_done,
    output logic                     ovf_err,
    output logic                     udf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = LEN_MSB - LEN_LSB + 2;
    localparam logic [AW:0] AF_LVL = (AW+1)'(AF_THRESH);

    logic [DATA_W:0]  mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             lfd_reg;
    logic [CW-1:0]    rem_cnt_reg;
    logic [CW-1:0]    rem_cnt_next;
    logic             pkt_done_next;
    logic [DATA_W:0]  rd_entry;
    logic             do_wr;
    logic             do_rd;

    assign empty       = (wr_ptr_reg == rd_ptr_reg);
    assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                         (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign fill_level  = wr_ptr_reg - rd_ptr_reg;
    assign almost_full = (fill_level >= AF_LVL);

    // Flags come from pre-edge pointers, so a write while full stays blocked
    // even when a read frees an entry in the same cycle.
    assign do_wr    = write_enb && !full && !soft_reset;
    assign do_rd    = read_enb && !empty && !soft_reset;
    assign rd_entry = mem[rd_ptr_reg[AW-1:0]];

    always_comb begin
        rem_cnt_next  = rem_cnt_reg;
        pkt_done_next = 1'b0;
        if (do_rd) begin
            if (rd_entry[DATA_W]) begin
                // Header reloads the counter: payload bytes plus one parity byte.
                rem_cnt_next = {1'b0, rd_entry[LEN_MSB:LEN_LSB]} + CW'(1);
            end else if (rem_cnt_reg != '0) begin
                rem_cnt_next  = rem_cnt_reg - CW'(1);
                pkt_done_next = (rem_cnt_reg == CW'(1));
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr_reg[AW-1:0]] <= {lfd_reg, data_in};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            lfd_reg     <= 1'b0;
            rem_cnt_reg <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            pkt_done    <= 1'b0;
            ovf_err     <= 1'b0;
            udf_err     <= 1'b0;
        end else if (soft_reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            lfd_reg     <= 1'b0;
            rem_cnt_reg <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            pkt_done    <= 1'b0;
            ovf_err     <= 1'b0;
            udf_err     <= 1'b0;
        end else begin
            lfd_reg     <= lfd_state;
            rem_cnt_reg <= rem_cnt_next;
            pkt_done    <= pkt_done_next;
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (write_enb && full) begin
                ovf_err <= 1'b1;
            end
            if (do_rd) begin
                data_out   <= rd_entry[DATA_W-1:0];
                data_valid <= 1'b1;
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end else begin
                data_valid <= 1'b0;
            end
            if (read_enb && empty) begin
                udf_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/router_pkt_fifo.md
Name: router_pkt_fifo

Overview:
- Parametrised packet FIFO for one router output channel.
- Stores each byte with a header tag and tracks the payload length from the header so end-of-packet is detected on the read side.
- Adds registered handshake outputs, occupancy, almost-full and sticky error flags.
- Sits between the router FSM/synchroniser and the destination read port, one instance per output channel.

Parameters:
- DATA_W, 8, data width in bits (min 8).
- DEPTH, 16, number of entries; power of 2, min 4.
- LEN_MSB, 7, MSB of the payload-length field in the header byte.
- LEN_LSB, 2, LSB of the payload-length field in the header byte.
- AF_THRESH, 14, fill level at or above which almost_full asserts (1..DEPTH).

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- soft_reset  in  1  synchronous channel flush, active-high.
- write_enb  in  1  write request.
- read_enb  in  1  read request.
- lfd_state  in  1  router FSM is in load-first-data state.
- data_in  in  DATA_W  write data.
- full  out  1  no free entry.
- empty  out  1  no stored entry.
- almost_full  out  1  fill_level >= AF_THRESH.
- fill_level  out  $clog2(DEPTH)+1  entries currently stored.
- data_out  out  DATA_W  registered read data.
- data_valid  out  1  data_out holds a byte read in the previous cycle.
- pkt_done  out  1  one-cycle pulse: last byte of a packet presented on data_out.
- ovf_err  out  1  sticky: write attempted while full.
- udf_err  out  1  sticky: read attempted while empty.

Behaviour:
- Storage: DEPTH x (DATA_W+1); bit DATA_W is the header tag.
- Pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = wrap bits differ and the low bits are equal.
  - Both flags are combinational from the registered pointers.
- Header tag: lfd_state is registered into lfd_q. A write in cycle t stores tag = lfd_q, i.e. lfd_state from cycle t-1.
- Write: if write_enb && !full, store {lfd_q, data_in} at wr_ptr, wr_ptr+1. If write_enb && full, no write and set ovf_err.
- Read: if read_enb && !empty, data_out <= mem[rd_ptr][DATA_W-1:0], data_valid <= 1, rd_ptr+1. Otherwise data_valid <= 0 and data_out holds.
  - Latency is 1 cycle from the read_enb edge to data_out.
  - If read_enb && empty, set udf_err.
- Simultaneous read and write:
  - Both succeed when neither is blocked, and fill_level is unchanged.
  - When full, the read succeeds and the write is blocked, because full is evaluated on the pre-edge state.
  - When empty, only the write succeeds.
- Fill level: fill_level = wr_ptr - rd_ptr, modulo 2^(AW+1). Value range 0..DEPTH.
- Packet counter (rem_cnt, width LEN_MSB-LEN_LSB+2):
  - On a read of a tagged entry: rem_cnt <= header[LEN_MSB:LEN_LSB] + 1, covering payload plus parity.
  - On a read of an untagged entry with rem_cnt != 0: rem_cnt - 1.
  - pkt_done is registered: it pulses in the cycle data_out shows the byte that moved rem_cnt from 1 to 0.
  - A header with length 0 gives a header + parity packet only.
- Tagged entry arriving while rem_cnt != 0 (truncated packet): the counter reloads from the new header and no pkt_done is issued for the old packet.
- Wrap-around: pointer low bits roll DEPTH-1 -> 0 and the wrap bit toggles. There is no bubble at the wrap.
- Asynchronous reset (resetn low), effective immediately and independent of clock:
  - pointers, lfd_q, rem_cnt = 0;
  - data_out = 0, data_valid = 0, pkt_done = 0;
  - ovf_err = 0, udf_err = 0;
  - memory contents are don't-care.
- Soft reset: synchronous, with priority over read and write in the same cycle.
  - Clears pointers, rem_cnt, lfd_q, data_out, data_valid, pkt_done and both error flags.
  - Reset mid-packet discards the partial packet; the next tagged write starts cleanly.
- No X or Z is ever driven on outputs.

Test Plan:
- Reset mid-operation: write 5 bytes, assert resetn low between clock edges -> full=0, empty=1, fill_level=0, data_out=0 immediately, before the next edge.
- Single packet: lfd_state=1 one cycle before writing header 8'h0C (len=3), then 3 payload bytes and 1 parity byte; read 5 -> data_out sequence 0C, p0, p1, p2, parity; data_valid high 5 cycles; pkt_done pulses with parity only.
- Full/overflow: write 16 bytes with DEPTH=16 -> full=1 and fill_level=16; a 17th write leaves contents unchanged and sets ovf_err. A simultaneous read+write while full -> one byte out, write blocked, fill_level=15.
- Wrap and almost_full: interleave 40 writes and 40 reads -> data order preserved across 2 wraps; almost_full asserts exactly when fill_level reaches 14 and deasserts at 13.
- Soft reset mid-packet: header len=10, 4 bytes read, soft_reset -> empty=1, rem_cnt=0, no pkt_done. A new len=1 packet then reads correctly with pkt_done on its parity byte.
- Underflow plus DEPTH=32/DATA_W=16 build: read while empty -> udf_err=1, data_valid=0, pointers unchanged. 32 writes then fill -> full=1.
